// File: rtl/sram_controller.sv
// Memory-stage SRAM controller: turns one 32-bit load/store into two 16-bit
// SRAM half-word cycles (LO, HI), a 3-cycle settle (WAIT) and a DONE handshake.
`timescale 1ns/1ps
module sram_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LO   = 3'd1;
    localparam logic [2:0] HI   = 3'd2;
    localparam logic [2:0] WAIT = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]  state_r;
    logic [1:0]  wait_cnt_r;
    logic        op_wr_r;
    logic [16:0] idx_r;
    logic [15:0] wdata_hi_r;
    logic [31:0] eff_s;
    logic        req_s;
    logic        unused_s;

    // Data memory is mapped at byte 1024; the low two bits select a byte and are dropped.
    assign eff_s    = address - 32'd1024;
    assign req_s    = rd_en | wr_en;
    assign unused_s = ^{eff_s[31:19], eff_s[1:0]};

    // Pipeline freeze: released only when idle with nothing to do, or finishing.
    always_comb begin
        ready = 1'b0;
        if (state_r == DONE) begin
            ready = 1'b1;
        end else if (state_r == IDLE) begin
            ready = ~req_s;
        end else begin
            ready = 1'b0;
        end
    end

    // Access sequencer; SRAM pins are loaded one edge ahead so they are valid throughout each state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            wait_cnt_r  <= 2'd0;
            op_wr_r     <= 1'b0;
            idx_r       <= 17'd0;
            wdata_hi_r  <= 16'd0;
            read_data   <= 32'd0;
            sram_addr   <= 18'd0;
            sram_dq_out <= 16'd0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        state_r     <= LO;
                        op_wr_r     <= wr_en;
                        idx_r       <= eff_s[18:2];
                        wdata_hi_r  <= write_data[31:16];
                        sram_addr   <= {eff_s[18:2], 1'b0};
                        sram_dq_out <= write_data[15:0];
                        sram_dq_oe  <= wr_en;
                        sram_we_n   <= ~wr_en;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LO: begin
                    state_r     <= HI;
                    sram_addr   <= {idx_r, 1'b1};
                    sram_dq_out <= wdata_hi_r;
                    if (!op_wr_r) begin
                        read_data[15:0] <= sram_dq_in;
                    end
                end
                HI: begin
                    state_r    <= WAIT;
                    wait_cnt_r <= 2'd0;
                    sram_dq_oe <= 1'b0;
                    sram_we_n  <= 1'b1;
                    if (!op_wr_r) begin
                        read_data[31:16] <= sram_dq_in;
                    end
                end
                WAIT: begin
                    if (wait_cnt_r == 2'd2) begin
                        state_r    <= DONE;
                        wait_cnt_r <= 2'd0;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 2'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r    <= IDLE;
                    wait_cnt_r <= 2'd0;
                    sram_dq_oe <= 1'b0;
                    sram_we_n  <= 1'b1;
                end
            endcase
        end
    end

endmodule
